scanline_receiver: RTL and testbench
====================================

// Module: scanline_receiver
// PURPOSE
//  Receive end of the scanline UART link. Deserialises 8N1 UART bytes from uart_rx and
//  packs BYTES_PER_LINE bytes into one scanline, first byte received into bits [7:0].
//  Pushes each completed scanline into the downstream scanline FIFO with a 1-cycle strobe.
//  Used on the host/display side to rebuild the 160-bit lines sent by the streamer.
// PARAMETERS
//  CLKS_PER_BIT    434     clk cycles per UART bit (50 MHz / 115200); must be >= 8
//  BYTES_PER_LINE  20      bytes per scanline; scanline width = 8*BYTES_PER_LINE
//  TIMEOUT_CLKS    4340    idle clks (no start bit) after which a partial line is discarded
// PORTS
//  clk          in   1    system clock, all logic on posedge
//  reset        in   1    synchronous, active-high
//  uart_rx      in   1    async serial input, idle high, 8N1, LSB first
//  fifo_full    in   1    downstream FIFO cannot accept a push this cycle
//  scanline     out  160  last completed line; held stable between pushes
//  fifo_push    out  1    1-cycle strobe: scanline valid, FIFO writes it
//  frame_error  out  1    1-cycle strobe: stop bit sampled low
//  overflow     out  1    1-cycle strobe: completed line dropped because fifo_full
// BEHAVIOUR
//  - Reset: scanline=0, fifo_push=0, frame_error=0, overflow=0; RX FSM->IDLE; byte index=0;
//    any partial line is discarded. Reset mid-byte or mid-line has the same effect.
//  - uart_rx passes through a 2-FF synchroniser (reset value 1) before use; latency 2 clks.
//  - Bit timer counts 0..CLKS_PER_BIT-1. Half-bit point = CLKS_PER_BIT/2 (integer divide).
//  - RX FSM:
//    IDLE : sync rx==0 -> START, timer=0.
//    START: at half-bit, rx==0 -> DATA (timer=0, bit=0); rx==1 -> IDLE (glitch, no strobe).
//    DATA : every CLKS_PER_BIT clks sample rx into shift reg, LSB first; after bit 7 -> STOP.
//    STOP : after CLKS_PER_BIT clks sample rx. 1 -> byte_done. 0 -> frame_error pulse,
//           byte dropped, byte index=0 (whole partial line discarded). Either way -> IDLE.
//    Sampling point is mid-bit throughout. IDLE is re-entered at mid-stop, so a start bit
//    following the stop bit with no gap is caught.
//  - Packing: on byte_done, byte written to buf[8*idx +: 8], idx++. Bytes of buf already
//    written keep their values; unwritten bytes are don't-care.
//  - Line complete (byte_done with idx==BYTES_PER_LINE-1), evaluated the same cycle:
//    !fifo_full -> next cycle scanline<=completed buf, fifo_push=1.
//    fifo_full  -> next cycle overflow=1, scanline unchanged, no push.
//    idx wraps to 0 in both cases.
//  - Latency: fifo_push rises 1 clk after the mid-stop sample of the last byte.
//  - Timeout: idle counter clears on every START entry. When idx!=0 and the counter
//    reaches TIMEOUT_CLKS while in IDLE -> idx=0, silent (no strobe). Counter saturates.
//  - Strobes are never asserted together and never for more than 1 cycle.
//    frame_error on the last byte of a line suppresses both push and overflow.
//  - fifo_full is sampled only in the completion cycle; it has no effect at other times.
// TESTING  (CLKS_PER_BIT=16, TIMEOUT_CLKS=400 in bench)
//  1 Send F0,EF,56,34,12,90,78,56,34,12,90,78,56,34,12,90,78,56,34,12 -> one fifo_push,
//    scanline==160'h1234567890123456789012345678901234_56EFF0 (read as
//    160'h123456789012345678901234567890123456EFF0); no other strobes.
//  2 5 good bytes, 6th byte with stop=0 -> frame_error 1 clk, no push; then a full 20-byte
//    line of 0xA5 -> push, scanline=={20{8'hA5}}.
//  3 Line of 0x3C with fifo_full=1 at completion -> overflow 1 clk, no push, scanline keeps
//    previous value; next line of 0xC3 with fifo_full=0 -> push, scanline=={20{8'hC3}}.
//  4 uart_rx low for 6 clks, then high -> no byte counted; the following 20-byte line
//    pushes exactly once with the correct data.
//  5 10 bytes of 0x11, idle 500 clks, then 20 bytes of 0x22 -> single push,
//    scanline=={20{8'h22}}.
//  6 Assert reset during the data bits of byte 12 -> all outputs 0; a following full
//    20-byte line pushes correctly. Send 40 back-to-back bytes, no gap between stop and
//    start -> exactly 2 pushes.

Source files
------------

// File: rtl/scanline_receiver.sv
// rtl/scanline_receiver.sv - 8N1 UART receiver that packs bytes into scanlines and pushes them to a FIFO
// A partial line is discarded on stop-bit error or after a long idle gap.
module scanline_receiver #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int BYTES_PER_LINE = 20,
    parameter int TIMEOUT_CLKS   = 4340
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        uart_rx,
    input  logic                        fifo_full,
    output logic [8*BYTES_PER_LINE-1:0] scanline,
    output logic                        fifo_push,
    output logic                        frame_error,
    output logic                        overflow
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(BYTES_PER_LINE);
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_CLK = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BYTES_PER_LINE - 1);
    localparam logic [CW-1:0] TMO      = CW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                          r_state, w_next;
    logic                            r_rx_meta, r_rx_sync;
    logic [TW-1:0]                   r_timer;
    logic [2:0]                      r_bit;
    logic [7:0]                      r_shift;
    logic [IW-1:0]                   r_idx;
    logic [CW-1:0]                   r_idle_cnt;
    // The last byte of a line goes straight to the output, so only N-1 bytes are buffered.
    logic [8*(BYTES_PER_LINE-1)-1:0] r_buf;
    logic                            w_timer_clr, w_sample, w_byte_done, w_frame_err;
    logic                            w_line_done, w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_state   <= S_IDLE;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_state   <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_timer_clr = 1'b0;
        w_sample    = 1'b0;
        w_byte_done = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_clr = 1'b1;
                if (!r_rx_sync) w_next = S_START;
            end
            S_START: begin
                if (r_timer == HALF_BIT) begin
                    w_timer_clr = 1'b1;
                    w_next      = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_timer == LAST_CLK) begin
                    w_timer_clr = 1'b1;
                    w_sample    = 1'b1;
                    if (r_bit == 3'd7) w_next = S_STOP;
                end
            end
            S_STOP: begin
                // Returning to IDLE at mid-stop lets a gapless next start bit be caught.
                if (r_timer == LAST_CLK) begin
                    w_timer_clr = 1'b1;
                    w_byte_done = r_rx_sync;
                    w_frame_err = !r_rx_sync;
                    w_next      = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_line_done = w_byte_done && (r_idx == IDX_LAST);
    assign w_timeout   = (r_state == S_IDLE) && (r_idle_cnt == TMO) && (r_idx != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_timer <= w_timer_clr ? '0 : r_timer + TW'(1);
            if (r_state == S_START)
                r_bit <= '0;
            else if (w_sample)
                r_bit <= r_bit + 3'd1;
            if (w_sample) r_shift <= {r_rx_sync, r_shift[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_idle_cnt <= '0;
        else if (r_state == S_IDLE && !r_rx_sync)
            r_idle_cnt <= '0;
        else if (r_state == S_IDLE && r_idle_cnt != TMO)
            r_idle_cnt <= r_idle_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_buf       <= '0;
            scanline    <= '0;
            fifo_push   <= 1'b0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            fifo_push   <= w_line_done && !fifo_full;
            overflow    <= w_line_done && fifo_full;
            frame_error <= w_frame_err;
            if (w_line_done && !fifo_full) scanline <= {r_shift, r_buf};
            if (w_frame_err || w_timeout || w_line_done) begin
                r_idx <= '0;
            end else if (w_byte_done) begin
                r_buf[8*r_idx +: 8] <= r_shift;
                r_idx               <= r_idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_scanline_receiver.sv
// tb/tb_scanline_receiver.sv - randomized scoreboard bench for scanline_receiver
module tb_scanline_receiver;
    localparam int CPB = 16;
    localparam int NB  = 20;
    localparam int TMO = 400;
    localparam int W   = 8 * NB;

    logic         clk = 1'b0;
    logic         reset, uart_rx, fifo_full;
    logic [W-1:0] scanline;
    logic         fifo_push, frame_error, overflow;

    always #5 clk = ~clk;

    scanline_receiver #(.CLKS_PER_BIT(CPB), .BYTES_PER_LINE(NB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .fifo_full(fifo_full),
        .scanline(scanline), .fifo_push(fifo_push), .frame_error(frame_error),
        .overflow(overflow)
    );

    typedef struct packed {
        logic [1:0]   kind;   // 0 push, 1 overflow, 2 frame error
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   model_bytes[$];
    logic [W-1:0] last_line = '0;
    int           vectors = 0;
    int           miscompares = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] k;
        if (!reset && (fifo_push || overflow || frame_error)) begin
            chk("strobe_onehot", W'($countones({fifo_push, overflow, frame_error})), W'(1));
            k = fifo_push ? 2'd0 : (overflow ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got kind %0d expected none", k);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", W'(k), W'(e.kind));
                if (fifo_push && e.kind == 2'd0) begin
                    chk("push_scanline", scanline, e.data);
                    last_line = e.data;
                end
                if (overflow) chk("overflow_scanline_held", scanline, last_line);
            end
        end
    end

    // Reference: bytes accumulate in a list; 20 good bytes form a line, first byte lowest.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic full);
        logic [W-1:0] line;
        if (stop) begin
            model_bytes.push_back(b);
            if (model_bytes.size() == NB) begin
                line = '0;
                for (int k = 0; k < NB; k++) line[8*k +: 8] = model_bytes[k];
                exp_q.push_back({full ? 2'd1 : 2'd0, line});
                model_bytes.delete();
            end
        end else begin
            exp_q.push_back({2'd2, {W{1'b0}}});
            model_bytes.delete();
        end
        fifo_full = full;
        uart_rx   = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx   = 1'b1;
        fifo_full = 1'b0;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
        if (n >= TMO + 50) model_bytes.delete();
    endtask

    task automatic send_line(input logic [7:0] v, input logic full);
        for (int i = 0; i < NB; i++)
            send_byte(v, 1'b1, (i == NB - 1) ? full : 1'($urandom_range(0, 1)));
    endtask

    logic [7:0] t1[NB] = '{8'hF0, 8'hEF, 8'h56, 8'h34, 8'h12, 8'h90, 8'h78, 8'h56, 8'h34, 8'h12,
                           8'h90, 8'h78, 8'h56, 8'h34, 8'h12, 8'h90, 8'h78, 8'h56, 8'h34, 8'h12};

    initial begin
        reset = 1'b1; uart_rx = 1'b1; fifo_full = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_scanline", scanline, '0);
        chk("reset_push", W'(fifo_push), '0);
        chk("reset_frame_error", W'(frame_error), '0);
        chk("reset_overflow", W'(overflow), '0);
        reset = 1'b0;
        idle(20);

        for (int i = 0; i < NB; i++) send_byte(t1[i], 1'b1, 1'b0);
        idle(40);
        chk("t1_scanline", scanline, 160'h123456789012345678901234567890123456EFF0);

        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        send_byte(8'($urandom), 1'b0, 1'b0);
        idle(40);
        send_line(8'hA5, 1'b0);
        idle(40);
        chk("t2_scanline", scanline, {NB{8'hA5}});

        send_line(8'h3C, 1'b1);
        idle(40);
        chk("t3_overflow_held", scanline, {NB{8'hA5}});
        send_line(8'hC3, 1'b0);
        idle(40);
        chk("t3_scanline", scanline, {NB{8'hC3}});

        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        idle(60);
        for (int i = 0; i < NB; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        idle(40);

        for (int i = 0; i < 10; i++) send_byte(8'h11, 1'b1, 1'b0);
        idle(500);
        send_line(8'h22, 1'b0);
        idle(40);
        chk("t5_scanline", scanline, {NB{8'h22}});

        for (int i = 0; i < 11; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx = 1'($urandom_range(0, 1));
            repeat (CPB) @(negedge clk);
        end
        reset = 1'b1; uart_rx = 1'b1;
        model_bytes.delete();
        repeat (3) @(negedge clk);
        chk("t6_reset_scanline", scanline, '0);
        chk("t6_reset_strobes", W'({fifo_push, overflow, frame_error}), '0);
        reset = 1'b0;
        last_line = '0;
        idle(40);
        send_line(8'h5A, 1'b0);
        idle(40);
        chk("t6_scanline", scanline, {NB{8'h5A}});
        for (int i = 0; i < 2 * NB; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        idle(60);

        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 29) == 0) begin
                    send_byte(8'($urandom), 1'b0, 1'b0);
                    idle(40);
                end
                send_byte(8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
                idle($urandom_range(0, 30));
            end
        end
        idle(600);

        chk("exp_queue_drained", W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
